axi_stream_header_extract: RTL and testbench
============================================

# axi_stream_header_extract

Receive-side counterpart of the header insertion block. It strips a per-packet header of 1 to DATA_BYTE_WD bytes from the front of an AXI-Stream packet and presents that header on a sideband port. It realigns the remaining payload to full output beats and regenerates keep/last. It sits on the ingress path, where packets built by the header inserter are consumed.

## Interface
- DATA_WD, 32: stream data width in bits (multiple of 8).
- DATA_BYTE_WD, DATA_WD/8: bytes per beat.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD)+1: width of the header byte count (must encode 0..DATA_BYTE_WD).
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- valid_extract  in  1  header length for the next packet is valid.
- byte_extract_cnt  in  BYTE_CNT_WD  header length N in bytes; 0 = pass-through.
- ready_extract  out  1  length accepted (high only in IDLE).
- valid_in / data_in / keep_in / last_in  in  1/DATA_WD/DATA_BYTE_WD/1  input stream; MSB byte first; keep contiguous and MSB-aligned.
- ready_in  out  1  input beat accepted.
- valid_out / data_out / keep_out / last_out  out  1/DATA_WD/DATA_BYTE_WD/1  payload stream, registered, same byte order.
- ready_out  in  1  downstream ready.
- valid_header  out  1  one-cycle pulse; header captured.
- data_header  out  DATA_WD  header right-aligned in the low bytes; unused bytes 0.
- keep_header  out  DATA_BYTE_WD  LSB-aligned mask of captured header bytes.

## Operation
- States:
  - IDLE: ready_extract=1, ready_in=0. A valid_extract handshake latches N and moves to FIRST, or to STREAM when N=0.
  - FIRST: accept beat 0. Its top N bytes go to data_header, with valid_header pulsed. Its low W−N bytes (W=DATA_BYTE_WD) go to a residue register.
  - STREAM: each accepted beat outputs {residue, top N bytes of beat}, and the residue is updated to the beat's low W−N bytes.
  - FLUSH: outputs the leftover residue as the final beat.
- Last beat with K valid bytes (K = popcount(keep_in)):
  - If K ≤ N: output {residue, top K bytes} with keep = MSB-aligned ones for W−N+K bytes, last_out=1, then go to IDLE.
  - If K > N: output a full beat, then go to FLUSH. FLUSH outputs K−N bytes with MSB-aligned keep and last_out=1, then goes to IDLE.
- Single-beat packet (last_in in FIRST):
  - The header gets min(K,N) bytes; keep_header reflects the bytes actually captured.
  - If K > N, one output beat carries K−N bytes with last_out=1.
  - If K ≤ N, no payload is emitted and the block returns to IDLE.
- N=0: beats pass through unchanged with 1-cycle latency, and valid_header is never pulsed.
- N > DATA_BYTE_WD is clamped to DATA_BYTE_WD.
- Invalid keep bytes on data_out are driven to 0.

## Timing
- Reset values:
  - valid_out, last_out, valid_header: 0.
  - data_out, keep_out, data_header, keep_header: 0.
  - ready_in: 0; ready_extract: 1 (state IDLE). The residue register is cleared.
- Asserting rst mid-packet discards the residue and any pending output and returns to IDLE on the next edge; no partial last is emitted.
- Output register: ready_in = (state is FIRST or STREAM) && (!valid_out || ready_out). In FLUSH and IDLE, ready_in=0.
- Output hold rules:
  - data_out/keep_out/last_out hold while valid_out && !ready_out.
  - valid_out drops the cycle after the final handshake unless a new beat is loaded.
- Latency:
  - Beat i (i≥1) accepted on edge t → its output is valid from t+1.
  - The header pulse is valid from the edge after beat 0 is accepted.
  - The FLUSH beat loads on the edge where the previous output handshakes.
- Sequencing:
  - Config and the first beat cannot be accepted in the same cycle; the minimum gap is 1 cycle.
  - The next packet's config may be accepted the cycle after entering IDLE, while the last output beat is still held.
- Full-rate throughput: one beat per clock while ready_out=1, plus one extra cycle per packet for FLUSH when K > N.

## Test plan
- N=3; beats 0xAABBCCDD, 0x11223344, last 0x55667788 keep 1100 → header 0x00AABBCC keep 0111; out 0xDD112233/1111, then 0x44556600/1110 last.
- N=1; beats 0x01020304, last 0x05060708 keep 1111 → header 0x00000001 keep 0001; out 0x02030405/1111, then FLUSH 0x06070800/1110 last.
- N=4; single beat 0xCAFEBABE keep 1111 last → header 0xCAFEBABE keep 1111; no valid_out; ready_extract back high next cycle.
- N=0; 5 beats with last keep 1000 → output identical to input, delayed 1 cycle; valid_header never asserted.
- N=2, 10 beats, ready_out toggled randomly → no beat lost or duplicated; data_out stable while stalled; byte sequence equals input minus first 2 bytes.
- rst pulsed mid-packet at beat 3 → all outputs 0 next cycle, ready_extract=1; the next packet extracts correctly.

Source files
------------

// File: rtl/axi_stream_header_extract_if.sv
// rtl/axi_stream_header_extract_if.sv - Config, stream and header sideband bundle for the header extractor
interface axi_stream_header_extract_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
);
  logic                    valid_extract;
  logic [BYTE_CNT_WD-1:0]  byte_extract_cnt;
  logic                    ready_extract;

  logic                    valid_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;
  logic                    ready_in;

  logic                    valid_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;
  logic                    ready_out;

  logic                    valid_header;
  logic [DATA_WD-1:0]      data_header;
  logic [DATA_BYTE_WD-1:0] keep_header;

  modport slave (
    input  valid_extract, byte_extract_cnt, valid_in, data_in, keep_in, last_in, ready_out,
    output ready_extract, ready_in, valid_out, data_out, keep_out, last_out,
           valid_header, data_header, keep_header
  );

  modport master (
    output valid_extract, byte_extract_cnt, valid_in, data_in, keep_in, last_in, ready_out,
    input  ready_extract, ready_in, valid_out, data_out, keep_out, last_out,
           valid_header, data_header, keep_header
  );
endinterface

// File: rtl/axi_stream_header_extract.sv
// rtl/axi_stream_header_extract.sv - Strips an N-byte header from each packet and realigns the payload
module axi_stream_header_extract #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  axi_stream_header_extract_if.slave bus
);
  localparam int W = DATA_BYTE_WD;

  typedef enum logic [1:0] {IDLE, FIRST, STREAM, FLUSH} state_t;

  state_t                 state_q, state_d;
  logic [BYTE_CNT_WD-1:0] n_q, n_d;
  logic [BYTE_CNT_WD-1:0] flush_cnt_q, flush_cnt_d;
  logic [DATA_WD-1:0]     residue_q, residue_d;
  logic                   valid_out_q, valid_out_d;
  logic                   last_out_q, last_out_d;
  logic [DATA_WD-1:0]     data_out_q, data_out_d;
  logic [W-1:0]           keep_out_q, keep_out_d;
  logic                   valid_header_q, valid_header_d;
  logic [DATA_WD-1:0]     data_header_q, data_header_d;
  logic [W-1:0]           keep_header_q, keep_header_d;

  logic                   out_free;
  logic                   ready_in;
  logic                   accept;
  logic [DATA_WD-1:0]     beat;
  logic [DATA_WD-1:0]     low_rem;
  logic [DATA_WD-1:0]     joined;
  int                     nb;
  int                     k;
  int                     hk;

  function automatic logic [W-1:0] msb_ones(input int cnt);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < W; i++) if (i < cnt) m[W-1-i] = 1'b1;
    return m;
  endfunction

  function automatic logic [W-1:0] lsb_ones(input int cnt);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < W; i++) if (i < cnt) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [W-1:0] keep);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < W; i++) m[8*i +: 8] = {8{keep[i]}};
    return m;
  endfunction

  function automatic int popcount(input logic [W-1:0] keep);
    int c;
    c = 0;
    for (int i = 0; i < W; i++) if (keep[i]) c++;
    return c;
  endfunction

  assign out_free = !valid_out_q || bus.ready_out;
  assign ready_in = ((state_q == FIRST) || (state_q == STREAM)) && out_free;
  assign accept   = bus.valid_in && ready_in;

  // Invalid input bytes are zeroed up front so every derived beat carries zeros there.
  assign nb      = int'(n_q);
  assign k       = popcount(bus.keep_in);
  assign beat    = bus.data_in & byte_mask(bus.keep_in);
  assign low_rem = beat & byte_mask(lsb_ones(W - nb));
  assign joined  = (residue_q << (8 * nb)) | (beat >> (8 * (W - nb)));

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    flush_cnt_d    = flush_cnt_q;
    residue_d      = residue_q;
    valid_out_d    = valid_out_q && !bus.ready_out;
    data_out_d     = data_out_q;
    keep_out_d     = keep_out_q;
    last_out_d     = last_out_q;
    valid_header_d = 1'b0;
    data_header_d  = data_header_q;
    keep_header_d  = keep_header_q;
    hk             = (bus.last_in && (k < nb)) ? k : nb;

    case (state_q)
      IDLE: begin
        if (bus.valid_extract) begin
          if (int'(bus.byte_extract_cnt) > W) n_d = BYTE_CNT_WD'(W);
          else                                n_d = bus.byte_extract_cnt;
          residue_d = '0;
          state_d   = (bus.byte_extract_cnt == '0) ? STREAM : FIRST;
        end
      end
      FIRST: begin
        if (accept) begin
          valid_header_d = 1'b1;
          data_header_d  = beat >> (8 * (W - hk));
          keep_header_d  = lsb_ones(hk);
          residue_d      = low_rem;
          state_d        = STREAM;
          if (bus.last_in) begin
            state_d = IDLE;
            if (k > nb) begin
              valid_out_d = 1'b1;
              data_out_d  = low_rem << (8 * nb);
              keep_out_d  = msb_ones(k - nb);
              last_out_d  = 1'b1;
            end
          end
        end
      end
      STREAM: begin
        if (accept) begin
          valid_out_d = 1'b1;
          if (nb == 0) begin
            data_out_d = beat;
            keep_out_d = bus.keep_in;
            last_out_d = bus.last_in;
            if (bus.last_in) state_d = IDLE;
          end else if (bus.last_in && (k <= nb)) begin
            data_out_d = joined;
            keep_out_d = msb_ones(W - nb + k);
            last_out_d = 1'b1;
            state_d    = IDLE;
          end else begin
            data_out_d = joined;
            keep_out_d = '1;
            last_out_d = 1'b0;
            residue_d  = low_rem;
            if (bus.last_in) begin
              flush_cnt_d = BYTE_CNT_WD'(k - nb);
              state_d     = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          valid_out_d = 1'b1;
          data_out_d  = residue_q << (8 * nb);
          keep_out_d  = msb_ones(int'(flush_cnt_q));
          last_out_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      n_q            <= '0;
      flush_cnt_q    <= '0;
      residue_q      <= '0;
      valid_out_q    <= 1'b0;
      data_out_q     <= '0;
      keep_out_q     <= '0;
      last_out_q     <= 1'b0;
      valid_header_q <= 1'b0;
      data_header_q  <= '0;
      keep_header_q  <= '0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      flush_cnt_q    <= flush_cnt_d;
      residue_q      <= residue_d;
      valid_out_q    <= valid_out_d;
      data_out_q     <= data_out_d;
      keep_out_q     <= keep_out_d;
      last_out_q     <= last_out_d;
      valid_header_q <= valid_header_d;
      data_header_q  <= data_header_d;
      keep_header_q  <= keep_header_d;
    end
  end

  assign bus.ready_extract = (state_q == IDLE);
  assign bus.ready_in      = ready_in;
  assign bus.valid_out     = valid_out_q;
  assign bus.data_out      = data_out_q;
  assign bus.keep_out      = keep_out_q;
  assign bus.last_out      = last_out_q;
  assign bus.valid_header  = valid_header_q;
  assign bus.data_header   = data_header_q;
  assign bus.keep_header   = keep_header_q;
endmodule

// File: tb/tb_axi_stream_header_extract.sv
// tb/tb_axi_stream_header_extract.sv - Directed and randomized self-checking bench for the header extractor
module tb_axi_stream_header_extract;
  localparam int DW     = 32;
  localparam int W      = 4;
  localparam int BUDGET = 2000;

  typedef logic [36:0] beat_t;  // {data, keep, last}
  typedef logic [35:0] hdr_t;   // {data, keep}

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_stream_header_extract_if #(.DATA_WD(DW)) bus ();

  axi_stream_header_extract #(.DATA_WD(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  bit         model_en = 1'b1;
  bit         rand_ready = 1'b0;
  beat_t      exp_out[$];
  beat_t      seen_out[$];
  hdr_t       exp_hdr[$];
  hdr_t       seen_hdr[$];
  logic [7:0] pkt[$];
  bit         prev_stall = 1'b0;
  beat_t      prev_word;
  beat_t      mon_b;
  hdr_t       mon_h;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timeout_fail(input string what);
    n_checks++;
    $display("FAIL timeout_%s: no progress within %0d cycles", what, BUDGET);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  initial begin
    bus.ready_out = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.ready_out = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: output beats and header pulses against the model queues.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      mon_b = {bus.data_out, bus.keep_out, bus.last_out};
      if (prev_stall) begin
        check("hold_valid", bus.valid_out, 1'b1);
        check("hold_beat", mon_b, prev_word);
      end
      prev_stall = bus.valid_out && !bus.ready_out;
      prev_word  = mon_b;
      if (bus.valid_out && bus.ready_out) begin
        seen_out.push_back(mon_b);
        if (model_en) begin
          if (exp_out.size() == 0) begin
            n_checks++;
            $display("FAIL out_unexpected: got %0h expected no beat", mon_b);
          end else begin
            check("out_beat", mon_b, exp_out.pop_front());
          end
        end
      end
      if (bus.valid_header) begin
        mon_h = {bus.data_header, bus.keep_header};
        seen_hdr.push_back(mon_h);
        if (model_en) begin
          if (exp_hdr.size() == 0) begin
            n_checks++;
            $display("FAIL hdr_unexpected: got %0h expected no header", mon_h);
          end else begin
            check("hdr", mon_h, exp_hdr.pop_front());
          end
        end
      end
    end
  end

  // Model: header = first min(N, bytes in beat 0) bytes; payload = remaining bytes packed into full beats.
  task automatic build_expected(input int n, input int nbeats, input int klast);
    int total, nc, k0, hb, cnt;
    logic [31:0] hd, d;
    logic [3:0]  hk, kp;
    total = pkt.size();
    nc = (n > W) ? W : n;
    k0 = (nbeats == 1) ? klast : W;
    if (nc > 0) begin
      hb = (nc < k0) ? nc : k0;
      hd = '0;
      hk = '0;
      for (int i = 0; i < hb; i++) begin
        hd = {hd[23:0], pkt[i]};
        hk[i] = 1'b1;
      end
      exp_hdr.push_back({hd, hk});
    end
    for (int i = nc; i < total; i += W) begin
      cnt = ((total - i) < W) ? (total - i) : W;
      d = '0;
      kp = '0;
      for (int j = 0; j < cnt; j++) begin
        d[DW-1-8*j -: 8] = pkt[i+j];
        kp[W-1-j] = 1'b1;
      end
      exp_out.push_back({d, kp, (i + W >= total)});
    end
  endtask

  function automatic logic [31:0] pkt_word(input int b, input int kk);
    logic [31:0] d;
    d = $urandom;
    for (int i = 0; i < kk; i++) d[DW-1-8*i -: 8] = pkt[b*W+i];
    return d;
  endfunction

  task automatic send_cfg(input int n);
    int cyc;
    bus.valid_extract = 1'b1;
    bus.byte_extract_cnt = 3'(n);
    cyc = 0;
    @(negedge clk);
    while (!bus.ready_extract) begin
      cyc++;
      if (cyc > BUDGET) timeout_fail("cfg");
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.valid_extract = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] kp, input logic lst);
    int cyc;
    bus.valid_in = 1'b1;
    bus.data_in  = d;
    bus.keep_in  = kp;
    bus.last_in  = lst;
    cyc = 0;
    @(negedge clk);
    while (!bus.ready_in) begin
      cyc++;
      if (cyc > BUDGET) timeout_fail("beat");
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic send_packet(input int n);
    int nbeats, klast, kk;
    logic [3:0] kp;
    nbeats = (pkt.size() + W - 1) / W;
    klast  = pkt.size() - W * (nbeats - 1);
    if (model_en) build_expected(n, nbeats, klast);
    send_cfg(n);
    for (int b = 0; b < nbeats; b++) begin
      kk = (b == nbeats - 1) ? klast : W;
      kp = 4'hF << (W - kk);
      send_beat(pkt_word(b, kk), kp, (b == nbeats - 1));
    end
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (exp_out.size() != 0 || exp_hdr.size() != 0) begin
      @(posedge clk);
      cyc++;
      if (cyc > BUDGET) timeout_fail("drain");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pkt(input int nbytes);
    pkt.delete();
    for (int i = 0; i < nbytes; i++) pkt.push_back(8'($urandom));
  endtask

  initial begin
    int base_o, base_h, total;
    beat_t b;
    bus.valid_extract = 1'b0;
    bus.byte_extract_cnt = '0;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    bus.keep_in  = '0;
    bus.last_in  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out", {bus.valid_out, bus.last_out, bus.keep_out, bus.data_out}, 64'd0);
    check("rst_hdr", {bus.valid_header, bus.keep_header, bus.data_header}, 64'd0);
    check("rst_ready", {bus.ready_extract, bus.ready_in}, 2'b10);
    @(posedge clk);
    #1;

    base_o = seen_out.size(); base_h = seen_hdr.size();
    pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_packet(3);
    drain();
    check("n3_hdr", seen_hdr[base_h], {32'h00AABBCC, 4'b0111});
    check("n3_out0", seen_out[base_o], {32'hDD112233, 4'b1111, 1'b0});
    check("n3_out1", seen_out[base_o+1], {32'h44556600, 4'b1110, 1'b1});
    check("n3_count", seen_out.size() - base_o, 2);

    base_o = seen_out.size(); base_h = seen_hdr.size();
    pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_packet(1);
    drain();
    check("n1_hdr", seen_hdr[base_h], {32'h00000001, 4'b0001});
    check("n1_out0", seen_out[base_o], {32'h02030405, 4'b1111, 1'b0});
    check("n1_flush", seen_out[base_o+1], {32'h06070800, 4'b1110, 1'b1});

    base_o = seen_out.size(); base_h = seen_hdr.size();
    pkt = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
    send_packet(4);
    @(negedge clk);
    check("n4_ready_extract", {bus.ready_extract, bus.valid_out}, 2'b10);
    drain();
    check("n4_hdr", seen_hdr[base_h], {32'hCAFEBABE, 4'b1111});
    check("n4_no_out", seen_out.size() - base_o, 0);

    base_o = seen_out.size(); base_h = seen_hdr.size();
    rand_pkt(17);
    send_packet(0);
    @(negedge clk);
    check("n0_last_latency", {bus.valid_out, bus.last_out, bus.keep_out}, 6'b111000);
    drain();
    check("n0_count", seen_out.size() - base_o, 5);
    check("n0_no_hdr", seen_hdr.size() - base_h, 0);

    base_o = seen_out.size();
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_packet(7);
    drain();
    check("clamp_out", seen_out[base_o], {32'h55667788, 4'b1111, 1'b1});

    base_o = seen_out.size();
    rand_ready = 1'b1;
    rand_pkt(40);
    send_packet(2);
    drain();
    total = 0;
    for (int i = base_o; i < seen_out.size(); i++) begin
      b = seen_out[i];
      total += $countones(b[4:1]);
    end
    check("n2_stall_bytes", total, 38);
    rand_ready = 1'b0;

    // Reset in the middle of a packet, then a clean packet.
    repeat (2) @(posedge clk);
    #1;
    model_en = 1'b0;
    rand_pkt(20);
    send_cfg(2);
    for (int i = 0; i < 3; i++) send_beat(pkt_word(i, W), 4'hF, 1'b0);
    bus.valid_in = 1'b1;
    bus.data_in  = pkt_word(3, W);
    bus.keep_in  = 4'hF;
    bus.last_in  = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.valid_in = 1'b0;
    @(negedge clk);
    check("mid_rst_out", {bus.valid_out, bus.last_out, bus.keep_out, bus.data_out}, 64'd0);
    check("mid_rst_hdr", {bus.valid_header, bus.keep_header, bus.data_header}, 64'd0);
    check("mid_rst_ready", {bus.ready_extract, bus.ready_in}, 2'b10);
    exp_out.delete();
    exp_hdr.delete();
    model_en = 1'b1;
    @(posedge clk);
    #1;
    base_o = seen_out.size(); base_h = seen_hdr.size();
    pkt = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    send_packet(2);
    drain();
    check("post_rst_hdr", seen_hdr[base_h], {32'h0000A0A1, 4'b0011});
    check("post_rst_out0", seen_out[base_o], {32'hA2A3A4A5, 4'b1111, 1'b0});
    check("post_rst_out1", seen_out[base_o+1], {32'hA6A70000, 4'b1100, 1'b1});

    rand_ready = 1'b1;
    for (int p = 0; p < 30; p++) begin
      rand_pkt(W * ($urandom_range(1, 6) - 1) + $urandom_range(1, W));
      send_packet($urandom_range(0, 7));
    end
    drain();
    check("final_out_queue", exp_out.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
